// File: rtl/mips_pkg.sv
// Shared types for the MIPS load/store unit: access sizes, FSM states and the
// byte-lane element used to build the big-endian memory word.
package mips_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } acc_size_t;

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE,
      DONE
   } lsu_state_t;

   // One byte lane; a memory word is lane_t [0:NBYTES-1], lane 0 most significant.
   typedef logic [7:0] lane_t;

endpackage

// File: rtl/mips_lsu_if.sv
// Core-side request/response and memory-side signals of the load/store unit.
// master = data path plus memory model, slave = mips_lsu.
interface mips_lsu_if import mips_pkg::*; #(
   parameter int XLEN = 32
);
   localparam int NBYTES = XLEN / 8;

   logic               req_valid;
   logic               req_ready;
   logic               req_write;
   logic [1:0]         req_size;
   logic               req_signed;
   logic [XLEN-1:0]    req_addr;
   logic [XLEN-1:0]    req_wdata;
   logic               resp_valid;
   logic [XLEN-1:0]    resp_rdata;
   logic               resp_error;
   logic               busy;
   logic [XLEN-1:0]    mem_addr;
   lane_t [0:NBYTES-1] mem_data_out;
   lane_t [0:NBYTES-1] mem_data_in;
   logic               mem_write_en;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_in,
      input  req_ready, resp_valid, resp_rdata, resp_error, busy,
             mem_addr, mem_data_out, mem_write_en
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_in,
      output req_ready, resp_valid, resp_rdata, resp_error, busy,
             mem_addr, mem_data_out, mem_write_en
   );
endinterface

// File: rtl/mips_lsu_align.sv
// Combinational load extract/extend and store lane merge for one memory word.
module lsu_align import mips_pkg::*; #(
   parameter int XLEN = 32
) (
   input  lane_t [0:XLEN/8-1]        word_in,
   input  acc_size_t                 size,
   input  logic [$clog2(XLEN/8)-1:0] offset,
   input  logic                      is_signed,
   input  logic [XLEN-1:0]           wdata,
   output logic [XLEN-1:0]           load_data,
   output lane_t [0:XLEN/8-1]        store_word
);
   localparam int NBYTES = XLEN / 8;
   localparam int OW     = $clog2(NBYTES);

   logic [OW:0]     nbytes;
   logic [OW+3:0]   shamt;
   logic [XLEN-1:0] word;
   logic [XLEN-1:0] mask;
   logic [XLEN-1:0] field;

   // Lane 0 is the lowest address, so the addressed bytes sit
   // (NBYTES - offset - nbytes) lanes above bit 0 of the packed word.
   always_comb begin
      // NOTE: every output is assigned before any condition, so no latch is inferred.
      word      = word_in;
      nbytes    = (OW+1)'(1) << size;
      shamt     = {(OW+1)'(NBYTES) - {1'b0, offset} - nbytes, 3'b000};
      mask      = (XLEN'(1) << {nbytes, 3'b000}) - XLEN'(1);
      field     = (word >> shamt) & mask;
      load_data = field;
      if (is_signed && |(field & (mask ^ (mask >> 1)))) begin
         load_data = field | ~mask;
      end
      store_word = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
   end
endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: request FSM, fixed read latency counter, read-modify-write
// for sub-word stores. Define MIPS_LSU_MISALIGN_TRAP_EN to reject misaligned accesses.
module mips_lsu import mips_pkg::*; #(
   parameter int XLEN        = 32,
   parameter int MEM_LATENCY = 1
) (
   input logic       clk,
   input logic       rst_b,
   mips_lsu_if.slave bus
);
   localparam int               NBYTES   = XLEN / 8;
   localparam int               OW       = $clog2(NBYTES);
   localparam int               CW       = $clog2(MEM_LATENCY + 1);
   localparam logic [CW-1:0]    CNT_INIT = CW'(MEM_LATENCY - 1);
   localparam acc_size_t        FULL_SZ  = acc_size_t'(OW);

   lsu_state_t         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   acc_size_t          size_q, size_d;
   logic [OW-1:0]      off_q, off_d;
   logic               signed_q, signed_d;
   logic               write_q, write_d;
   logic               error_q, error_d;
   logic [XLEN-1:0]    wdata_q, wdata_d;
   logic [XLEN-1:0]    addr_q, addr_d;
   logic [XLEN-1:0]    rdata_q, rdata_d;
   lane_t [0:NBYTES-1] wbuf_q, wbuf_d;

   acc_size_t          req_sz;
   logic [OW-1:0]      align_mask;
   logic [OW-1:0]      req_off;
   logic               req_bad;
   logic [XLEN-1:0]    load_data;
   lane_t [0:NBYTES-1] store_word;

   // Request decode: effective size, lane offset and rejection.
   always_comb begin
      req_sz = acc_size_t'(bus.req_size);
      if (XLEN == 32 && req_sz == SZ_DWORD) begin
         req_sz = SZ_WORD;
      end
      align_mask = OW'((1 << req_sz) - 1);
`ifdef MIPS_LSU_MISALIGN_TRAP_EN
      req_off = bus.req_addr[OW-1:0];
      req_bad = (XLEN == 32 && bus.req_size == 2'd3) ||
                (|(bus.req_addr[OW-1:0] & align_mask));
`else
      req_off = bus.req_addr[OW-1:0] & ~align_mask;
      req_bad = 1'b0;
`endif
   end

   lsu_align #(.XLEN(XLEN)) u_align (
      .word_in    (bus.mem_data_in),
      .size       (size_q),
      .offset     (off_q),
      .is_signed  (signed_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      size_d   = size_q;
      off_d    = off_q;
      signed_d = signed_q;
      write_d  = write_q;
      error_d  = error_q;
      wdata_d  = wdata_q;
      addr_d   = addr_q;
      rdata_d  = rdata_q;
      wbuf_d   = wbuf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               size_d   = req_sz;
               off_d    = req_off;
               signed_d = bus.req_signed;
               write_d  = bus.req_write;
               error_d  = req_bad;
               wdata_d  = bus.req_wdata;
               addr_d   = {bus.req_addr[XLEN-1:OW], OW'(0)};
               if (req_bad) begin
                  state_d = DONE;
               end else if (bus.req_write && req_sz == FULL_SZ) begin
                  wbuf_d  = bus.req_wdata;
                  state_d = WRITE;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = READ_WAIT;
               end
            end
         end
         READ_WAIT: begin
            if (cnt_q == '0) begin
               if (write_q) begin
                  wbuf_d  = store_word;
                  state_d = WRITE;
               end else begin
                  rdata_d = load_data;
                  state_d = DONE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_b) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         size_q   <= SZ_BYTE;
         off_q    <= '0;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         error_q  <= 1'b0;
         wdata_q  <= '0;
         addr_q   <= '0;
         rdata_q  <= '0;
         wbuf_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         size_q   <= size_d;
         off_q    <= off_d;
         signed_q <= signed_d;
         write_q  <= write_d;
         error_q  <= error_d;
         wdata_q  <= wdata_d;
         addr_q   <= addr_d;
         rdata_q  <= rdata_d;
         wbuf_q   <= wbuf_d;
      end
   end

   // Strobes decode straight from the state flop, so reset drops them at once.
   assign bus.req_ready    = (state_q == IDLE);
   assign bus.busy         = (state_q != IDLE);
   assign bus.resp_valid   = (state_q == DONE);
   assign bus.mem_write_en = (state_q == WRITE);
   assign bus.resp_rdata   = rdata_q;
   assign bus.resp_error   = error_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_data_out = wbuf_q;
endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: three instances (32b/lat1, 32b/lat3, 64b/lat2) on a shared
// byte memory, checked against a byte-addressed big-endian reference model.
module tb_mips_lsu;
   logic clk   = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

`ifdef MIPS_LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   int          sel        = 0;
   logic        req_valid  = 1'b0;
   logic        req_write  = 1'b0;
   logic        req_signed = 1'b0;
   logic [1:0]  req_size   = 2'd0;
   logic [63:0] req_addr   = '0;
   logic [63:0] req_wdata  = '0;

   logic        o_ready, o_valid, o_error, o_busy, o_we;
   logic [63:0] o_rdata, o_addr, o_dout;

   logic [7:0]  mem     [0:1023];
   logic [7:0]  ref_mem [0:1023];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;

   mips_lsu_if #(.XLEN(32)) if_a ();
   mips_lsu_if #(.XLEN(32)) if_b ();
   mips_lsu_if #(.XLEN(64)) if_c ();

   mips_lsu #(.XLEN(32), .MEM_LATENCY(1)) dut_a (.clk(clk), .rst_b(rst_b), .bus(if_a));
   mips_lsu #(.XLEN(32), .MEM_LATENCY(3)) dut_b (.clk(clk), .rst_b(rst_b), .bus(if_b));
   mips_lsu #(.XLEN(64), .MEM_LATENCY(2)) dut_c (.clk(clk), .rst_b(rst_b), .bus(if_c));

   assign if_a.req_valid  = req_valid && (sel == 0);
   assign if_a.req_write  = req_write;
   assign if_a.req_size   = req_size;
   assign if_a.req_signed = req_signed;
   assign if_a.req_addr   = req_addr[31:0];
   assign if_a.req_wdata  = req_wdata[31:0];
   assign if_b.req_valid  = req_valid && (sel == 1);
   assign if_b.req_write  = req_write;
   assign if_b.req_size   = req_size;
   assign if_b.req_signed = req_signed;
   assign if_b.req_addr   = req_addr[31:0];
   assign if_b.req_wdata  = req_wdata[31:0];
   assign if_c.req_valid  = req_valid && (sel == 2);
   assign if_c.req_write  = req_write;
   assign if_c.req_size   = req_size;
   assign if_c.req_signed = req_signed;
   assign if_c.req_addr   = req_addr;
   assign if_c.req_wdata  = req_wdata;

   always_comb for (int i = 0; i < 4; i++) if_a.mem_data_in[i] = mem[if_a.mem_addr[9:0] + 10'(i)];
   always_comb for (int i = 0; i < 4; i++) if_b.mem_data_in[i] = mem[if_b.mem_addr[9:0] + 10'(i)];
   always_comb for (int i = 0; i < 8; i++) if_c.mem_data_in[i] = mem[if_c.mem_addr[9:0] + 10'(i)];

   always_comb begin
      o_ready = if_a.req_ready;   o_valid = if_a.resp_valid;
      o_error = if_a.resp_error;  o_busy  = if_a.busy;
      o_we    = if_a.mem_write_en;
      o_rdata = 64'(if_a.resp_rdata);
      o_addr  = 64'(if_a.mem_addr);
      o_dout  = 64'(if_a.mem_data_out);
      if (sel == 1) begin
         o_ready = if_b.req_ready;   o_valid = if_b.resp_valid;
         o_error = if_b.resp_error;  o_busy  = if_b.busy;
         o_we    = if_b.mem_write_en;
         o_rdata = 64'(if_b.resp_rdata);
         o_addr  = 64'(if_b.mem_addr);
         o_dout  = 64'(if_b.mem_data_out);
      end else if (sel == 2) begin
         o_ready = if_c.req_ready;   o_valid = if_c.resp_valid;
         o_error = if_c.resp_error;  o_busy  = if_c.busy;
         o_we    = if_c.mem_write_en;
         o_rdata = if_c.resp_rdata;
         o_addr  = if_c.mem_addr;
         o_dout  = if_c.mem_data_out;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: access width in bytes, rejection, byte-wise load/store.
   function automatic int acc_bytes(int xlen, logic [1:0] sz);
      if (xlen == 32 && sz == 2'd3) return 4;
      return 1 << sz;
   endfunction

   function automatic bit acc_rejected(int xlen, logic [1:0] sz, logic [63:0] a);
      return TRAP && ((xlen == 32 && sz == 2'd3) || (a % (64'd1 << sz) != 0));
   endfunction

   function automatic logic [63:0] ref_load(int xlen, int n, logic [63:0] ea, bit sg);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[ea[9:0] + 10'(i)]);
      if (sg && v[8*n-1] && n < 8) v = v | ~((64'd1 << (8*n)) - 64'd1);
      if (xlen == 32) v[63:32] = '0;
      return v;
   endfunction

   task automatic ref_store(int n, logic [63:0] ea, logic [63:0] wd);
      for (int i = 0; i < n; i++) ref_mem[ea[9:0] + 10'(i)] = wd[8*(n-1-i) +: 8];
   endtask

   function automatic logic [63:0] ref_word(int nb, logic [63:0] wa);
      logic [63:0] v = '0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 64'(ref_mem[wa[9:0] + 10'(i)]);
      return v;
   endfunction

   task automatic poke(input logic [9:0] a, input logic [7:0] d);
      mem[a]     = d;
      ref_mem[a] = d;
   endtask

   // One complete access on instance s; checks timing, write data and response.
   task automatic xact(input int s, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [63:0] a, input logic [63:0] wd, output logic [63:0] rd);
      int          xlen, lat, n, nb, we_cyc, rsp_cyc, exp_we, exp_rsp;
      bit          err;
      logic [63:0] ea, exp_rd, exp_word;
      xlen     = (s == 2) ? 64 : 32;
      lat      = (s == 0) ? 1 : (s == 1) ? 3 : 2;
      nb       = xlen / 8;
      n        = acc_bytes(xlen, sz);
      err      = acc_rejected(xlen, sz, a);
      ea       = a - (a % 64'(n));
      exp_rd   = '0;
      exp_word = '0;
      exp_we   = -1;
      if (err) begin
         exp_rsp = 1;
      end else if (!wr) begin
         exp_rd  = ref_load(xlen, n, ea, sg);
         exp_rsp = 1 + lat;
      end else begin
         ref_store(n, ea, wd);
         exp_word = ref_word(nb, a - (a % 64'(nb)));
         exp_we   = (n == nb) ? 1 : 1 + lat;
         exp_rsp  = exp_we + 1;
      end

      @(negedge clk);
      sel = s;
      #1;
      check("ready_before_req", 64'(o_ready), 64'd1);
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;

      we_cyc  = -1;
      rsp_cyc = -1;
      rd      = '0;
      for (int c = 1; c <= 24 && rsp_cyc < 0; c++) begin
         @(negedge clk);
         check("busy_in_flight", 64'(o_busy), 64'd1);
         if (c == 1 && !err) check("mem_addr", o_addr, a - (a % 64'(nb)));
         if (o_we === 1'b1) begin
            we_cyc = c;
            if (wr) check("store_word", o_dout, exp_word);
            for (int i = 0; i < nb; i++) mem[o_addr[9:0] + 10'(i)] = o_dout[8*(nb-1-i) +: 8];
         end
         if (o_valid === 1'b1) begin
            rsp_cyc = c;
            rd      = o_rdata;
            check("resp_error", 64'(o_error), 64'(err));
            if (!wr && !err) check("load_data", o_rdata, exp_rd);
         end
      end
      check("resp_cycle", 64'(rsp_cyc), 64'(exp_rsp));
      check("write_cycle", 64'(we_cyc), 64'(exp_we));
      @(negedge clk);
      check("ready_after", 64'(o_ready), 64'd1);
      check("valid_one_cycle", 64'(o_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] rd;

      for (int i = 0; i < 1024; i++) poke(10'(i), 8'($urandom));
      poke(10'h100, 8'h88); poke(10'h101, 8'h99); poke(10'h102, 8'hAA); poke(10'h103, 8'hBB);
      poke(10'h180, 8'h80); poke(10'h181, 8'h00);
      poke(10'h1C0, 8'hF0); poke(10'h1C1, 8'h12); poke(10'h1C2, 8'h34); poke(10'h1C3, 8'h56);
      poke(10'h1C4, 8'h78); poke(10'h1C5, 8'h9A); poke(10'h1C6, 8'hBC); poke(10'h1C7, 8'hDE);

      // Reset values on every instance, then ready once released.
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("rst_busy", 64'(o_busy), 64'd0);
         check("rst_resp_valid", 64'(o_valid), 64'd0);
         check("rst_resp_rdata", o_rdata, 64'd0);
         check("rst_resp_error", 64'(o_error), 64'd0);
         check("rst_mem_addr", o_addr, 64'd0);
         check("rst_mem_data_out", o_dout, 64'd0);
         check("rst_mem_write_en", 64'(o_we), 64'd0);
      end
      rst_b = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("ready_out_of_reset", 64'(o_ready), 64'd1);
      end

      // Directed cases from the access rules.
      xact(0, 1'b0, 2'd0, 1'b1, 64'h101, '0, rd);
      check("lb_signed_0x101", rd, 64'hFFFF_FF99);
      xact(0, 1'b0, 2'd0, 1'b0, 64'h101, '0, rd);
      check("lbu_0x101", rd, 64'h0000_0099);
      xact(0, 1'b0, 2'd2, 1'b0, 64'h103, '0, rd);
`ifndef MIPS_LSU_MISALIGN_TRAP_EN
      check("lw_misaligned_reads_0x100", rd, 64'h8899_AABB);
`endif
      xact(0, 1'b1, 2'd2, 1'b0, 64'h200, 64'hDEAD_BEEF, rd);
      check("sw_mem_0x200", {32'd0, mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]},
            64'hDEAD_BEEF);
      xact(1, 1'b1, 2'd1, 1'b0, 64'h102, 64'h1234, rd);
      check("sh_rmw_mem_0x100", {32'd0, mem[10'h100], mem[10'h101], mem[10'h102], mem[10'h103]},
            64'h8899_1234);
      xact(2, 1'b0, 2'd3, 1'b1, 64'h1C0, '0, rd);
      check("ld_signed_64", rd, 64'hF012_3456_789A_BCDE);
      xact(2, 1'b0, 2'd1, 1'b1, 64'h180, '0, rd);
      check("lh_signed_64", rd, 64'hFFFF_FFFF_FFFF_8000);

      // Reset while a full-width store is in WRITE: strobe drops, no response.
      @(negedge clk);
      sel        = 1;
      req_write  = 1'b1;
      req_size   = 2'd2;
      req_signed = 1'b0;
      req_addr   = 64'h300;
      req_wdata  = 64'hCAFE_F00D;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_we_before", 64'(o_we), 64'd1);
      rst_b = 1'b0;
      #1;
      check("rst_mid_we_async_drop", 64'(o_we), 64'd0);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("rst_mid_no_resp", 64'(o_valid), 64'd0);
      end
      check("rst_mid_ready", 64'(o_ready), 64'd1);
      check("rst_mid_busy", 64'(o_busy), 64'd0);

      // Random accesses across all three instances.
      for (int t = 0; t < 90; t++) begin
         xact(int'($urandom_range(0, 2)), 1'($urandom), 2'($urandom), 1'($urandom),
              64'($urandom_range(0, 1023)), {$urandom, $urandom}, rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
